mem_wb_hilo: RTL
================

MEM_WB_HILO -- requirements
Module: mem_wb_hilo

Interface
REQ-001 SHALL have port `clock`, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port `reset`, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have inputs `write_reg_address_input` (5), `write_reg_enable_input` (1) and `write_reg_data_input` (32): the memory stage's register write-back request.
REQ-004 SHALL have inputs `hi_input` (32), `lo_input` (32) and `whilo_input` (1): the memory stage's HI/LO write request.
REQ-005 SHALL have inputs `stall_mem` (1) and `stall_wb` (1): pipeline stall controls for the memory and write-back stages.
REQ-006 SHALL have outputs `write_reg_address_output` (5), `write_reg_enable_output` (1) and `write_reg_data_output` (32): the registered write-back request to the register file.
REQ-007 SHALL have outputs `hi_output` (32) and `lo_output` (32): the committed HI/LO architectural values.
REQ-008 SHALL have outputs `hi_read` (32) and `lo_read` (32): the HI/LO read port for the execute stage.
REQ-009 SHALL have output `hilo_hazard` (1): the execute stage must stall while it is high.

Function
REQ-010 SHALL latch all memory-stage inputs into the write-back register on a clock edge when stall_mem=0.
REQ-011 SHALL load a bubble (address 0, enables 0, data 0) into the write-back register when stall_mem=1 and stall_wb=0.
REQ-012 SHALL hold the write-back register unchanged when stall_mem=1 and stall_wb=1.
REQ-013 SHALL drive write_reg_*_output directly from the write-back register, giving a latency of 1 cycle from input to output.
REQ-014 SHALL commit the write-back stage's hi/lo to the HI/LO registers on the next edge when the write-back whilo=1 and stall_wb=0, giving a latency of 2 cycles from whilo_input.
REQ-015 SHALL drive hi_output and lo_output from the HI/LO registers only.
REQ-016 SHALL keep HI and LO unchanged when the write-back whilo=0.
REQ-017 SHALL write HI and LO together; partial writes are not supported.
REQ-018 SHALL commit HI/LO only once when stall_wb=1 holds a whilo entry, even across repeated held cycles.
REQ-019 SHALL treat a whilo=1 entry at the memory stage and another at write-back in the same cycle (back-to-back writes) as both committing in order, with the newer value final.
REQ-020 SHALL drive a zero-word bubble when the write-back register holds write_reg_enable=0 and whilo=0, and SHALL NOT commit to HI/LO for it.

Reset
REQ-021 SHALL clear the write-back register and the HI/LO registers to zero immediately (asynchronously) while reset=0.
REQ-022 SHALL drive all outputs to zero while reset=0, with hilo_hazard=0.
REQ-023 SHALL discard any in-flight HI/LO write on reset assertion mid-operation; no commit SHALL occur after release.
REQ-024 SHALL perform its first capture on the first rising edge after reset deasserts.

Configuration
REQ-025 SHALL use the macro HILO_BYPASS_EN.
REQ-026 SHALL, when HILO_BYPASS_EN is defined, drive hi_read/lo_read as hi_input/lo_input if whilo_input=1, else write-back hi/lo if write-back whilo=1, else the HI/LO registers; hilo_hazard SHALL be tied to 0.
REQ-027 SHALL, when HILO_BYPASS_EN is undefined, drive hi_read/lo_read from the HI/LO registers only, and assert hilo_hazard whenever whilo_input=1 or write-back whilo=1.

Verification
REQ-028 SHALL cover this scenario: write_reg_address_input=5'd3, write_reg_enable_input=1, write_reg_data_input=32'h1234_5678, one edge -> outputs 3/1/32'h1234_5678.
REQ-029 SHALL cover this scenario: whilo_input=1, hi_input=32'hAAAA_0001, lo_input=32'h5555_0002 for 1 cycle -> hi_output/lo_output update after 2 edges; with bypass, hi_read=32'hAAAA_0001 in the same cycle.
REQ-030 SHALL cover this scenario: stall_mem=1, stall_wb=0 with valid input -> write_reg_enable_output=0 next cycle; then stall_mem=1, stall_wb=1 -> outputs held for 3 cycles.
REQ-031 SHALL cover this scenario: back-to-back whilo writes HI=1 then HI=2 -> hi_output ends at 2; bypass read shows 2 while both are in flight.
REQ-032 SHALL cover this scenario: without HILO_BYPASS_EN, whilo_input=1 -> hilo_hazard=1 for 2 cycles, then 0 with hi_read equal to the new value.
REQ-033 SHALL cover this scenario: reset=0 asserted mid-cycle with a pending whilo -> all outputs 0 immediately, and HI stays 0 after release.

Source files
------------

// File: rtl/mem_wb_hilo_if.sv
// Memory-to-write-back pipeline bundle: the memory-stage requests, the stall
// controls, and the write-back / HI-LO results seen by the register file and execute stage.
interface mem_wb_hilo_if;
  logic [4:0]  write_reg_address_input;
  logic        write_reg_enable_input;
  logic [31:0] write_reg_data_input;
  logic [31:0] hi_input;
  logic [31:0] lo_input;
  logic        whilo_input;
  logic        stall_mem;
  logic        stall_wb;

  logic [4:0]  write_reg_address_output;
  logic        write_reg_enable_output;
  logic [31:0] write_reg_data_output;
  logic [31:0] hi_output;
  logic [31:0] lo_output;
  logic [31:0] hi_read;
  logic [31:0] lo_read;
  logic        hilo_hazard;

  modport master (
    output write_reg_address_input, write_reg_enable_input, write_reg_data_input,
    output hi_input, lo_input, whilo_input, stall_mem, stall_wb,
    input  write_reg_address_output, write_reg_enable_output, write_reg_data_output,
    input  hi_output, lo_output, hi_read, lo_read, hilo_hazard
  );

  modport slave (
    input  write_reg_address_input, write_reg_enable_input, write_reg_data_input,
    input  hi_input, lo_input, whilo_input, stall_mem, stall_wb,
    output write_reg_address_output, write_reg_enable_output, write_reg_data_output,
    output hi_output, lo_output, hi_read, lo_read, hilo_hazard
  );
endinterface

// File: rtl/mem_wb_hilo.sv
// MEM/WB pipeline register with the HI/LO architectural registers behind it.
// Define HILO_BYPASS_EN to forward in-flight HI/LO writes to the execute read port instead of stalling.
module mem_wb_hilo (
  input logic          clock,
  input logic          reset,
  mem_wb_hilo_if.slave bus
);

  logic [4:0]  wb_addr;
  logic        wb_en;
  logic [31:0] wb_data;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        wb_whilo;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic [31:0] hi_mux;
  logic [31:0] lo_mux;
  logic        hazard_raw;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_addr  <= '0;
      wb_en    <= 1'b0;
      wb_data  <= '0;
      wb_hi    <= '0;
      wb_lo    <= '0;
      wb_whilo <= 1'b0;
    end else if (!bus.stall_mem) begin
      wb_addr  <= bus.write_reg_address_input;
      wb_en    <= bus.write_reg_enable_input;
      wb_data  <= bus.write_reg_data_input;
      wb_hi    <= bus.hi_input;
      wb_lo    <= bus.lo_input;
      wb_whilo <= bus.whilo_input;
    end else if (!bus.stall_wb) begin
      wb_addr  <= '0;
      wb_en    <= 1'b0;
      wb_data  <= '0;
      wb_hi    <= '0;
      wb_lo    <= '0;
      wb_whilo <= 1'b0;
    end
  end

  // A held write-back entry commits only on the edge that releases it, so never twice.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (wb_whilo && !bus.stall_wb) begin
      hi_reg <= wb_hi;
      lo_reg <= wb_lo;
    end
  end

`ifdef HILO_BYPASS_EN
  always_comb begin
    hi_mux = hi_reg;
    lo_mux = lo_reg;
    if (bus.whilo_input) begin
      hi_mux = bus.hi_input;
      lo_mux = bus.lo_input;
    end else if (wb_whilo) begin
      hi_mux = wb_hi;
      lo_mux = wb_lo;
    end
  end
  assign hazard_raw = 1'b0;
`else
  assign hi_mux     = hi_reg;
  assign lo_mux     = lo_reg;
  assign hazard_raw = bus.whilo_input | wb_whilo;
`endif

  // Paths straight from the inputs are gated so every output reads zero during reset.
  assign bus.hi_read     = reset ? hi_mux : '0;
  assign bus.lo_read     = reset ? lo_mux : '0;
  assign bus.hilo_hazard = reset & hazard_raw;

  assign bus.write_reg_address_output = wb_addr;
  assign bus.write_reg_enable_output  = wb_en;
  assign bus.write_reg_data_output    = wb_data;
  assign bus.hi_output                = hi_reg;
  assign bus.lo_output                = lo_reg;

endmodule
